// File: rtl/ram_test_controller.sv
// ram_test_controller: sequences generator -> RAM -> checker loopback frames.
// Owns RAM write/read addressing, the generator/checker start pulses and the
// per-session pass/fail tally. Single clock, synchronous active-high reset.
//
// Handshake note: there is no backpressure anywhere on this path. i_gen_valid
// qualifies one generator word per cycle and is written the same cycle it is
// seen; o_ram_re issues one read per cycle; o_chk_data_valid qualifies one RAM
// output word per cycle, RD_LAT cycles after the matching o_ram_re.
module ram_test_controller #(
    parameter int FRAME_LEN = 16,
    parameter int ADDR_W    = 5,
    parameter int RD_LAT    = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_run,
    input  logic [7:0]        i_num_frames,
    output logic              o_gen_start,
    input  logic              i_gen_valid,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_waddr,
    output logic              o_ram_re,
    output logic [ADDR_W-1:0] o_ram_raddr,
    output logic              o_chk_start,
    output logic              o_chk_data_valid,
    input  logic              i_chk_done,
    input  logic              i_chk_valid_frame,
    output logic              o_busy,
    output logic              o_done,
    output logic [7:0]        o_pass_cnt,
    output logic [7:0]        o_fail_cnt,
    output logic              o_len_err,
    output logic              o_timeout
);

    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] CNT_MAX = '1;
    localparam logic [ADDR_W-1:0] LEN_W   = ADDR_W'(FRAME_LEN);
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN_START,
        S_WRITE,
        S_READ,
        S_CHECK_WAIT,
        S_NEXT
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          rem_q, rem_d;
    logic [7:0]          pass_q, pass_d;
    logic [7:0]          fail_q, fail_d;
    logic                len_err_q, len_err_d;
    logic                timeout_q, timeout_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                vprev_q, vprev_d;
    logic                frame_fail_q, frame_fail_d;
    logic                frame_pass_q, frame_pass_d;
    logic [RD_LAT-1:0]   re_pipe_q, re_pipe_d;
    logic [RD_LAT-1:0]   first_pipe_q, first_pipe_d;

    logic ram_we;
    logic ram_re;
    logic first_rd;

    // Datapath strobes decoded from the current state.
    always_comb begin
        ram_we   = (state_q == S_WRITE) && i_gen_valid && (cnt_q != CNT_MAX);
        ram_re   = (state_q == S_READ);
        first_rd = ram_re && (raddr_q == '0);
    end

    // Next-state, counters and sticky flags for the frame sequencer.
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        pass_d       = pass_q;
        fail_d       = fail_q;
        len_err_d    = len_err_q;
        timeout_d    = timeout_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        waddr_d      = waddr_q;
        cnt_d        = cnt_q;
        raddr_d      = raddr_q;
        wd_d         = wd_q;
        vprev_d      = vprev_q;
        frame_fail_d = frame_fail_q;
        frame_pass_d = frame_pass_q;

        case (state_q)
            S_IDLE: begin
                // done_q high means a session just ended this cycle; a run
                // request colliding with it is dropped.
                if (i_run && !done_q) begin
                    pass_d    = '0;
                    fail_d    = '0;
                    len_err_d = 1'b0;
                    timeout_d = 1'b0;
                    rem_d     = i_num_frames;
                    if (i_num_frames == 8'd0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = S_GEN_START;
                    end
                end
            end
            S_GEN_START: begin
                waddr_d      = '0;
                cnt_d        = '0;
                raddr_d      = '0;
                wd_d         = '0;
                vprev_d      = 1'b0;
                frame_fail_d = 1'b0;
                frame_pass_d = 1'b0;
                state_d      = S_WRITE;
            end
            S_WRITE: begin
                vprev_d = i_gen_valid;
                if (ram_we) begin
                    waddr_d = waddr_q + ADDR_W'(1);
                    cnt_d   = cnt_q + ADDR_W'(1);
                    wd_d    = '0;
                end else if (!i_gen_valid && vprev_q && (cnt_q != '0)) begin
                    // Falling edge of valid closes the frame.
                    state_d = S_READ;
                    raddr_d = '0;
                    wd_d    = '0;
                    if (cnt_q != LEN_W) begin
                        len_err_d    = 1'b1;
                        frame_fail_d = 1'b1;
                    end
                end else if (wd_q == WD_LAST) begin
                    timeout_d    = 1'b1;
                    frame_fail_d = 1'b1;
                    state_d      = S_NEXT;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_READ: begin
                raddr_d = raddr_q + ADDR_W'(1);
                wd_d    = '0;
                if (raddr_q == cnt_q - ADDR_W'(1)) begin
                    state_d = S_CHECK_WAIT;
                end
            end
            S_CHECK_WAIT: begin
                if (i_chk_done) begin
                    frame_pass_d = i_chk_valid_frame && !frame_fail_q;
                    state_d      = S_NEXT;
                end else if (wd_q == WD_LAST) begin
                    timeout_d    = 1'b1;
                    frame_pass_d = 1'b0;
                    state_d      = S_NEXT;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_NEXT: begin
                if (frame_pass_q) begin
                    pass_d = pass_q + 8'd1;
                end else begin
                    fail_d = fail_q + 8'd1;
                end
                rem_d = rem_q - 8'd1;
                if (rem_q == 8'd1) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_GEN_START;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Checker drive delay line; independent of the sequencer state so the
    // tail of a frame drains even after the FSM has moved on.
    always_comb begin
        re_pipe_d       = re_pipe_q;
        first_pipe_d    = first_pipe_q;
        re_pipe_d[0]    = ram_re;
        first_pipe_d[0] = first_rd;
        for (int i = 1; i < RD_LAT; i++) begin
            re_pipe_d[i]    = re_pipe_q[i-1];
            first_pipe_d[i] = first_pipe_q[i-1];
        end
    end

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            rem_q        <= '0;
            pass_q       <= '0;
            fail_q       <= '0;
            len_err_q    <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            waddr_q      <= '0;
            cnt_q        <= '0;
            raddr_q      <= '0;
            wd_q         <= '0;
            vprev_q      <= 1'b0;
            frame_fail_q <= 1'b0;
            frame_pass_q <= 1'b0;
            re_pipe_q    <= '0;
            first_pipe_q <= '0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            len_err_q    <= len_err_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            waddr_q      <= waddr_d;
            cnt_q        <= cnt_d;
            raddr_q      <= raddr_d;
            wd_q         <= wd_d;
            vprev_q      <= vprev_d;
            frame_fail_q <= frame_fail_d;
            frame_pass_q <= frame_pass_d;
            re_pipe_q    <= re_pipe_d;
            first_pipe_q <= first_pipe_d;
        end
    end

    // Output mapping.
    always_comb begin
        o_gen_start      = (state_q == S_GEN_START);
        o_ram_we         = ram_we;
        o_ram_waddr      = waddr_q;
        o_ram_re         = ram_re;
        o_ram_raddr      = raddr_q;
        o_chk_start      = first_pipe_q[RD_LAT-1];
        o_chk_data_valid = re_pipe_q[RD_LAT-1];
        o_busy           = busy_q;
        o_done           = done_q;
        o_pass_cnt       = pass_q;
        o_fail_cnt       = fail_q;
        o_len_err        = len_err_q;
        o_timeout        = timeout_q;
    end

endmodule

// File: doc/ram_test_controller.md
# ram_test_controller

Sequencing controller for the RAM loopback test path. On a run request it executes a programmable number of frames. For each frame it starts the data generator, writes every generated word into the RAM, reads the frame back in order, drives the data checker, and tallies pass/fail results. It sits between the top-level test control and the generator/RAM/checker datapath, and owns all RAM addressing and the start pulses.

## Interface
- FRAME_LEN, 16: expected words per frame from the generator.
- ADDR_W, 5: RAM address width; 2^ADDR_W >= FRAME_LEN is required.
- RD_LAT, 1: RAM read latency in clocks (1..4).
- TIMEOUT, 255: watchdog limit in clocks for the WRITE and CHECK_WAIT states.

Ports:
- i_clk  in  1  system clock; single clock domain.
- i_rst  in  1  reset; synchronous, active-high.
- i_run  in  1  pulse that starts a session; ignored while o_busy=1.
- i_num_frames  in  8  number of frames per session; sampled on i_run.
- o_gen_start  out  1  one-clock start pulse to the data generator.
- i_gen_valid  in  1  generator data-valid.
- o_ram_we  out  1  RAM write enable.
- o_ram_waddr  out  ADDR_W  RAM write address.
- o_ram_re  out  1  RAM read enable.
- o_ram_raddr  out  ADDR_W  RAM read address.
- o_chk_start  out  1  one-clock start pulse to the checker.
- o_chk_data_valid  out  1  checker i_data_valid; this is o_ram_re delayed RD_LAT clocks.
- i_chk_done  in  1  checker checking-done pulse.
- i_chk_valid_frame  in  1  checker frame-valid pulse.
- o_busy  out  1  high from the cycle after an accepted i_run until o_done.
- o_done  out  1  one-clock pulse at session end.
- o_pass_cnt  out  8  frames passed in the current session.
- o_fail_cnt  out  8  frames failed in the current session.
- o_len_err  out  1  sticky: a frame length differed from FRAME_LEN.
- o_timeout  out  1  sticky: the watchdog expired.

## Operation
- States: IDLE, GEN_START, WRITE, READ, CHECK_WAIT, NEXT.
- IDLE:
  - When i_run=1, latch i_num_frames into the remaining counter, clear the pass/fail counters and sticky flags, and go to GEN_START.
  - If i_num_frames=0, skip the frame loop: pulse o_done the next cycle and stay in IDLE.
- GEN_START:
  - o_gen_start=1 for one cycle.
  - Clear the write address, word count and watchdog.
  - Go to WRITE.
- WRITE:
  - o_ram_we = i_gen_valid (combinational, gated by the state).
  - o_ram_waddr is the registered address; it increments on each write.
  - Word count increments on each write and saturates at 2^ADDR_W−1. Writes beyond that are suppressed (o_ram_we=0).
  - End of WRITE: falling edge of i_gen_valid after at least one word. Then go to READ.
  - If the word count is not FRAME_LEN at that point, set o_len_err and mark the frame failed.
  - Watchdog: if no write happens within TIMEOUT clocks, set o_timeout, mark the frame failed, and go to NEXT.
- READ:
  - o_ram_re=1 for exactly word-count cycles, with o_ram_raddr = 0,1,…,count−1.
  - Then go to CHECK_WAIT.
- Checker drive is a delay line that runs independently of the state:
  - o_chk_data_valid = o_ram_re delayed RD_LAT.
  - o_chk_start pulses exactly RD_LAT clocks after the first o_ram_re of the frame, which is the cycle the first read word appears on the RAM output.
- CHECK_WAIT:
  - On i_chk_done=1, the frame passes if i_chk_valid_frame=1 (sampled the same cycle) and it was not already marked failed. Otherwise it fails. Go to NEXT.
  - Watchdog: after TIMEOUT clocks, set o_timeout, fail the frame, and go to NEXT.
- NEXT:
  - Increment o_pass_cnt or o_fail_cnt (exactly one per frame) and decrement the remaining counter.
  - If remaining reaches 0: pulse o_done, drop o_busy, go to IDLE. Otherwise go to GEN_START.
- Counters and sticky flags hold their values after o_done until the next accepted i_run.
- After a timeout, generator and checker sequences may be misaligned. Later frames then fail; a system i_rst is required to realign them.

## Timing
- Reset behaviour: on i_rst, state becomes IDLE.
  - All outputs are 0: pulses, enables, addresses, counters, sticky flags and the delay line.
  - Reset mid-frame aborts immediately and no result is recorded.
- Cycle 0: i_run=1. Cycle 1: o_busy=1 and o_gen_start=1.
- Writes follow i_gen_valid with zero added latency.
- The first o_ram_re is the cycle after the WRITE end detection.
- o_chk_start is at first-read + RD_LAT.
- A frame result is counted in NEXT, one cycle after i_chk_done.
- o_done is asserted in the same cycle o_busy falls.
- An i_run that coincides with o_done is ignored.

## Test plan
- FRAME_LEN=16, RD_LAT=1, i_num_frames=1, correct RAM → addresses 0..15 written then read, o_chk_start one cycle after the first o_ram_re, o_pass_cnt=1, o_fail_cnt=0, one o_done pulse.
- i_num_frames=3 with a RAM bit corrupted in frame 2 → o_pass_cnt=2, o_fail_cnt=1, o_len_err=0.
- Generator delivers 12 words → o_len_err=1 and the frame fails; READ issues exactly 12 reads.
- i_chk_done never arrives, TIMEOUT=255 → o_timeout=1, o_fail_cnt=1, o_done 255 clocks after entering CHECK_WAIT plus 1.
- i_num_frames=0 → o_done one cycle after i_run, o_busy never high, counters 0.
- i_rst asserted mid-READ, then i_run with RD_LAT=3 → all outputs 0 after reset; the new session passes with o_chk_start three cycles after the first read.
